// File: rtl/pipe_pkg.sv
// Shared MEM/WB definitions: WB control bit positions and the packed stage payload.
package pipe_pkg;

  localparam int unsigned WB_REGWRITE = 0;
  localparam int unsigned WB_MEMTOREG = 1;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_REG_W  = 5;
  localparam int unsigned DEF_WB_W   = 2;

  // Field order matches the flattened payload vector used inside the stage
  typedef struct packed {
    logic [DEF_WB_W-1:0]   wb;
    logic [DEF_DATA_W-1:0] data_mem;
    logic [DEF_DATA_W-1:0] add;
    logic [DEF_REG_W-1:0]  regd;
  } memwb_t;

  function automatic int unsigned memwb_width(input int unsigned wb_w,
                                              input int unsigned data_w,
                                              input int unsigned reg_w);
    return wb_w + 2 * data_w + reg_w;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry valid/ready skid buffer with synchronous flush; in_ready comes straight from a flop.
module pipe_skid_buf #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         main_valid_q, main_valid_n;
  logic         skid_valid_q, skid_valid_n;
  logic         ready_q, ready_n;
  logic [W-1:0] main_q, main_n;
  logic [W-1:0] skid_q, skid_n;
  logic         accept;
  logic         emit;

  assign accept = in_valid & ready_q;
  assign emit   = main_valid_q & out_ready;

  // Next-state: refill main from skid first, otherwise take the new entry into whichever slot frees up
  always_comb begin
    main_valid_n = main_valid_q;
    skid_valid_n = skid_valid_q;
    main_n       = main_q;
    skid_n       = skid_q;
    if (flush) begin
      main_valid_n = 1'b0;
      skid_valid_n = 1'b0;
    end else if (emit && skid_valid_q) begin
      main_n       = skid_q;
      skid_valid_n = 1'b0;
    end else if (emit || !main_valid_q) begin
      main_valid_n = accept;
      if (accept) main_n = in_data;
    end else if (accept) begin
      skid_valid_n = 1'b1;
      skid_n       = in_data;
    end
    ready_n = ~skid_valid_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b1;
      main_q       <= '0;
      skid_q       <= '0;
    end else begin
      main_valid_q <= main_valid_n;
      skid_valid_q <= skid_valid_n;
      ready_q      <= ready_n;
      main_q       <= main_n;
      skid_q       <= skid_n;
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_q;

endmodule

// File: rtl/memwb_pipe_stage.sv
// MEM/WB pipeline register with valid/ready handshake, optional skid entry, flush and stall counter.
module memwb_pipe_stage
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned WB_W   = 2,
  parameter int unsigned SKID   = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_in,
  input  logic              flush_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WB_W-1:0]   WB_in,
  input  logic [DATA_W-1:0] Add_in,
  input  logic [DATA_W-1:0] DataMem_in,
  input  logic [REG_W-1:0]  Regd_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WB_W-1:0]   WB_out,
  output logic [DATA_W-1:0] Add_out,
  output logic [DATA_W-1:0] DataMem_out,
  output logic [REG_W-1:0]  Regd_out,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int unsigned PAY_W = memwb_width(WB_W, DATA_W, REG_W);

  logic [PAY_W-1:0] in_pay;
  logic [PAY_W-1:0] main_pay;
  logic             main_valid;

  assign in_pay = {WB_in, DataMem_in, Add_in, Regd_in};

  if (SKID != 0) begin : g_skid
    pipe_skid_buf #(.W(PAY_W)) u_skid_buf (
      .clk       (clk),
      .rst       (reset_in),
      .flush     (flush_in),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_pay),
      .out_valid (main_valid),
      .out_ready (out_ready),
      .out_data  (main_pay)
    );
  end else begin : g_single
    // Single entry: ready passes through combinationally so full throughput needs no second slot
    assign in_ready = out_ready | ~main_valid;

    always_ff @(posedge clk or posedge reset_in) begin
      if (reset_in) begin
        main_valid <= 1'b0;
        main_pay   <= '0;
      end else if (flush_in) begin
        main_valid <= 1'b0;
      end else if (in_valid && in_ready) begin
        main_valid <= 1'b1;
        main_pay   <= in_pay;
      end else if (main_valid && out_ready) begin
        main_valid <= 1'b0;
      end
    end
  end

  // Masking WB keeps a stale RegWrite from reaching the register file
  assign out_valid   = main_valid;
  assign WB_out      = main_valid ? main_pay[PAY_W-1 -: WB_W] : '0;
  assign DataMem_out = main_pay[REG_W+DATA_W +: DATA_W];
  assign Add_out     = main_pay[REG_W +: DATA_W];
  assign Regd_out    = main_pay[REG_W-1:0];

  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      stall_cnt <= '0;
    end else if (main_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
